tdr_ring_ctrl: RTL and testbench

// - Single-clock measurement sequencer for one ring_oscillator cell of the time-domain register.
// - Drives the cell's rstb/tsc_i/carry_b/re controls and opens a programmable sample window.
// - Counts ring_o rising edges, synchronised into clk, during that window.
// - Presents the saturating count to the readout path with a valid/ready handshake.

---
 rtl/tdr_pkg.sv | 28 ++
 rtl/tdr_sync.sv | 37 +++
 rtl/tdr_ring_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tdr_ring_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdr_pkg.sv
// tdr_pkg: shared types and default sizing for the time-domain register
// ring-oscillator measurement controller.
//   state_t           : sequencer states
//   TDR_CNT_W         : default edge counter width
//   TDR_WIN_W         : default sample-window length width
//   TDR_SYNC_STAGES   : default depth of the ring_i synchroniser
//   is_counting()     : states in which synchronised ring edges are counted
package tdr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    READ
  } state_t;

  localparam int TDR_CNT_W       = 8;
  localparam int TDR_WIN_W       = 8;
  localparam int TDR_SYNC_STAGES = 2;

  // Edges are counted while the window is open and while the edges that were
  // already in flight through the synchroniser drain out afterwards.
  function automatic logic is_counting(state_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/tdr_sync.sv
// tdr_sync: multi-flop synchroniser that brings the asynchronous ring_o
// signal into the clk domain.
// Ports:
//   clk   in  system clock
//   rstb  in  asynchronous active-low reset, clears the chain to 0
//   clr   in  synchronous clear, empties the chain before a new measurement
//   d     in  asynchronous input
//   q     out synchronised output (last flop of the chain)
module tdr_sync
  import tdr_pkg::*;
#(
  parameter int STAGES = TDR_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // A synchronous clear is used so that stale ring levels from a previous
  // measurement cannot appear as a rising edge in the next window.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      chain <= '0;
    end else if (clr) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tdr_ring_ctrl.sv
// tdr_ring_ctrl: measurement sequencer for one ring-oscillator cell of the
// time-domain register. Arms the cell, opens a programmable sample window,
// counts synchronised ring_i rising edges (saturating), and hands the count
// to the readout path with a valid/ready handshake.
// Ports:
//   clk          in   system clock
//   rstb         in   asynchronous active-low reset
//   start_i      in   one-cycle measurement request, ignored while busy_o
//   win_len_i    in   window length in clk cycles, 0 treated as 1
//   ring_i       in   ring_o of the oscillator cell (asynchronous)
//   ring_rstb_o  out  cell rstb, 0 holds the ring off
//   tsc_o        out  cell tsc_i, 1 while the sample window is open
//   carry_b_o    out  cell carry_b, 0 stops the ring once the count saturates
//   re_o         out  cell re, 1 freezes the ring during readout
//   count_o      out  saturating edge count
//   ovf_o        out  count saturated during this measurement
//   valid_o      out  result available
//   ready_i      in   consumer accepts the result when valid_o && ready_i
//   busy_o       out  1 whenever the sequencer is not idle
module tdr_ring_ctrl
  import tdr_pkg::*;
#(
  parameter int CNT_W       = TDR_CNT_W,
  parameter int WIN_W       = TDR_WIN_W,
  parameter int SYNC_STAGES = TDR_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             ring_i,
  output logic             ring_rstb_o,
  output logic             tsc_o,
  output logic             carry_b_o,
  output logic             re_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam int               DRAIN_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(SYNC_STAGES);
  localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);

  state_t             state;
  logic [WIN_W-1:0]   win_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               sync_q;
  logic               prev_q;
  logic               sync_clr;
  logic               rise;

  // The synchroniser and edge detector are emptied during ARM so the first
  // RUN cycle always starts from a known low history.
  assign sync_clr = (state == ARM);
  assign rise     = sync_q & ~prev_q;

  tdr_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstb(rstb),
    .clr (sync_clr),
    .d   (ring_i),
    .q   (sync_q)
  );

  // Previous synchronised level, used to turn levels into single-cycle rises.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev_q <= 1'b0;
    end else if (state == ARM) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_q;
    end
  end

  // Sequencer, window/drain counters, edge counter and all registered cell
  // controls. Every output is a flop so the analog cell sees glitch-free
  // control lines. Outputs are set on the edge entering a state so their
  // level matches the state for its whole duration.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      win_cnt     <= '0;
      drain_cnt   <= '0;
      ring_rstb_o <= 1'b0;
      tsc_o       <= 1'b0;
      carry_b_o   <= 1'b1;
      re_o        <= 1'b0;
      count_o     <= '0;
      ovf_o       <= 1'b0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      ring_rstb_o <= 1'b1;

      // Saturating count; reaching the maximum stops the ring via carry_b
      // and flags overflow until the next measurement is armed.
      if (is_counting(state) && rise && (count_o != CNT_MAX)) begin
        count_o <= count_o + 1'b1;
        if (count_o == CNT_MAX - 1'b1) begin
          ovf_o     <= 1'b1;
          carry_b_o <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= ARM;
            win_cnt     <= (win_len_i == '0) ? WIN_ONE : win_len_i;
            ring_rstb_o <= 1'b0;
            busy_o      <= 1'b1;
            count_o     <= '0;
            ovf_o       <= 1'b0;
            carry_b_o   <= 1'b1;
          end
        end
        ARM: begin
          state <= RUN;
          tsc_o <= 1'b1;
        end
        RUN: begin
          if (win_cnt == WIN_ONE) begin
            state     <= DRAIN;
            tsc_o     <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state   <= READ;
            re_o    <= 1'b1;
            valid_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        READ: begin
          if (ready_i) begin
            state   <= IDLE;
            re_o    <= 1'b0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdr_ring_ctrl.sv
// tb_tdr_ring_ctrl: randomized self-checking bench for tdr_ring_ctrl.
// The ring input is driven on falling clk edges and its value at every rising
// edge is logged; the reference model derives the expected count from that
// log: a ring rise sampled on edge k is counted when k lies in the window
// [N+2, N+W+2] (N = edge that accepted start_i), capped at 2**CNT_W-1.
module tb_tdr_ring_ctrl;

  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int MASK  = 16383;

  logic             clk;
  logic             rstb;
  logic             start_i;
  logic [WIN_W-1:0] win_len_i;
  logic             ring_i;
  logic             ring_rstb_o;
  logic             tsc_o;
  logic             carry_b_o;
  logic             re_o;
  logic [CNT_W-1:0] count_o;
  logic             ovf_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ring_mode = 0;
  int   ring_ph  = 0;
  logic hist [0:MASK];

  tdr_ring_ctrl #(
    .CNT_W      (CNT_W),
    .WIN_W      (WIN_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start_i    (start_i),
    .win_len_i  (win_len_i),
    .ring_i     (ring_i),
    .ring_rstb_o(ring_rstb_o),
    .tsc_o      (tsc_o),
    .carry_b_o  (carry_b_o),
    .re_o       (re_o),
    .count_o    (count_o),
    .ovf_o      (ovf_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log the ring level seen at each rising edge, indexed by edge number.
  always @(posedge clk) begin
    hist[cyc & MASK] <= ring_i;
    cyc <= cyc + 1;
  end

  // Ring pattern generator: 0 static low, 1 clk/4, 2 clk/2, 3 random.
  always @(negedge clk) begin
    ring_ph = ring_ph + 1;
    case (ring_mode)
      0:       ring_i = 1'b0;
      1:       if (ring_ph % 2 == 0) ring_i = ~ring_i;
      2:       ring_i = ~ring_i;
      default: ring_i = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s obs=%0d exp=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Raw number of counted rises after edge e for a measurement accepted on
  // edge n with effective window w.
  function automatic int model_rises(int n, int w, int e);
    int   r;
    int   last;
    logic p;
    r = 0;
    p = 1'b0;
    last = (e - SYNC < n + w + 2) ? e - SYNC : n + w + 2;
    for (int k = n + 2; k <= last; k++) begin
      if (hist[k & MASK] && !p) r++;
      p = hist[k & MASK];
    end
    return r;
  endfunction

  function automatic int sat(int r);
    return (r > MAXV) ? MAXV : r;
  endfunction

  // One full measurement starting at the current falling edge, with rd cycles
  // of ready_i low in READ (random start_i pulses there must be ignored).
  task automatic applyStimulus(input int win, input int mode, input int rd);
    int n, w, ev, exp_r, fin_r;
    ring_mode = mode;
    start_i   = 1'b1;
    ready_i   = 1'b0;
    win_len_i = WIN_W'(win);
    @(negedge clk);
    start_i = 1'b0;
    n  = cyc - 1;
    w  = (win == 0) ? 1 : win;
    ev = n + w + SYNC + 2;
    for (int e = n; e <= ev; e++) begin
      if (e != n) @(negedge clk);
      exp_r = model_rises(n, w, e);
      checkOutput("tsc", int'(tsc_o), int'(e >= n + 1 && e <= n + w));
      checkOutput("ring_rstb", int'(ring_rstb_o), int'(e != n));
      checkOutput("busy", int'(busy_o), 1);
      checkOutput("valid", int'(valid_o), int'(e == ev));
      checkOutput("re", int'(re_o), int'(e == ev));
      checkOutput("count", int'(count_o), sat(exp_r));
      checkOutput("ovf", int'(ovf_o), int'(exp_r >= MAXV));
      checkOutput("carry_b", int'(carry_b_o), int'(exp_r < MAXV));
    end
    fin_r = model_rises(n, w, ev);
    for (int j = 0; j < rd; j++) begin
      start_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      start_i = 1'b0;
      checkOutput("hold_valid", int'(valid_o), 1);
      checkOutput("hold_re", int'(re_o), 1);
      checkOutput("hold_count", int'(count_o), sat(fin_r));
      checkOutput("hold_ovf", int'(ovf_o), int'(fin_r >= MAXV));
      checkOutput("hold_busy", int'(busy_o), 1);
    end
    ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    start_i = 1'b0;
    checkOutput("hs_valid", int'(valid_o), 0);
    checkOutput("hs_re", int'(re_o), 0);
    checkOutput("hs_busy", int'(busy_o), 0);
    checkOutput("hs_tsc", int'(tsc_o), 0);
    checkOutput("hs_count", int'(count_o), sat(fin_r));
    checkOutput("hs_carry_b", int'(carry_b_o), int'(fin_r < MAXV));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ring_rstb"}, int'(ring_rstb_o), 0);
    checkOutput({tag, "_tsc"}, int'(tsc_o), 0);
    checkOutput({tag, "_carry_b"}, int'(carry_b_o), 1);
    checkOutput({tag, "_re"}, int'(re_o), 0);
    checkOutput({tag, "_count"}, int'(count_o), 0);
    checkOutput({tag, "_ovf"}, int'(ovf_o), 0);
    checkOutput({tag, "_valid"}, int'(valid_o), 0);
    checkOutput({tag, "_busy"}, int'(busy_o), 0);
  endtask

  task automatic idleCycles(input int k);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      checkOutput("idle_busy", int'(busy_o), 0);
      checkOutput("idle_valid", int'(valid_o), 0);
      checkOutput("idle_ring_rstb", int'(ring_rstb_o), 1);
    end
  endtask

  initial begin
    rstb      = 1'b0;
    start_i   = 1'b0;
    ready_i   = 1'b0;
    win_len_i = '0;
    ring_i    = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    rstb = 1'b1;
    idleCycles(2);

    $display("[TB] basic window 10, ring clk/4");
    applyStimulus(10, 1, 2);
    idleCycles(1);

    $display("[TB] zero window, static ring");
    applyStimulus(0, 0, 1);
    idleCycles(1);

    $display("[TB] saturation window 200, ring clk/2");
    applyStimulus(200, 2, 3);

    $display("[TB] handshake stall 20 cycles");
    applyStimulus(12, 1, 20);

    $display("[TB] back-to-back measurements");
    applyStimulus(40, 2, 0);
    applyStimulus(5, 3, 1);

    $display("[TB] randomized measurements");
    for (int i = 0; i < 12; i++) begin
      applyStimulus($urandom_range(0, 40), $urandom_range(1, 3), $urandom_range(0, 4));
      idleCycles($urandom_range(0, 2));
    end

    $display("[TB] reset mid-measurement");
    ring_mode = 3;
    start_i   = 1'b1;
    win_len_i = WIN_W'(30);
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("pre_rst_tsc", int'(tsc_o), 1);
    #2;
    rstb = 1'b0;
    #1;
    checkResetValues("mid_rst");
    @(negedge clk);
    rstb = 1'b1;
    idleCycles(40);

    $display("[TB] measurement after reset");
    applyStimulus(9, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
